// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and datapath.
// States, opcodes, mux selects, ALU/ext ops, decode class, control bundle.
package mc_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXE    = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_HALT   = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
    logic jr;
    logic illegal;
  } instr_cls_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] extop;
    logic       retire;
    logic       illegal;
  } ctrl_t;

  // Instruction classes that write rt from the ALU (immediate forms).
  function automatic logic is_imm_alu(instr_cls_t c);
    return c.ori | c.lui;
  endfunction

endpackage

// File: rtl/mc_instr_decode.sv
// Combinational op/func -> one-hot instruction class.
// Ports: i_op, i_func (IR fields) -> o_cls (exactly one bit set).
module mc_instr_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output instr_cls_t o_cls
);

  always_comb begin
    o_cls = '0;
    case (i_op)
      OP_RTYPE: begin
        case (i_func)
          FN_ADDU: o_cls.addu    = 1'b1;
          FN_SUBU: o_cls.subu    = 1'b1;
          FN_JR:   o_cls.jr      = 1'b1;
          default: o_cls.illegal = 1'b1;
        endcase
      end
      OP_ORI:  o_cls.ori     = 1'b1;
      OP_LW:   o_cls.lw      = 1'b1;
      OP_SW:   o_cls.sw      = 1'b1;
      OP_BEQ:  o_cls.beq     = 1'b1;
      OP_LUI:  o_cls.lui     = 1'b1;
      OP_J:    o_cls.j       = 1'b1;
      OP_JAL:  o_cls.jal     = 1'b1;
      default: o_cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS controller FSM driving PC/IR/regfile/ALU/memory.
// In: clk, reset, op, func, mem_ready. Out: datapath enables/selects, retire, illegal.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter logic ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] extop,
  output logic       retire,
  output logic       illegal
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  instr_cls_t w_cls;
  ctrl_t      w_ctrl;
  ctrl_t      w_out;

  mc_instr_decode u_dec (
    .i_op   (op),
    .i_func (func),
    .o_cls  (w_cls)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          w_cls.lw, w_cls.sw:
            w_next = S_MEMADR;
          w_cls.addu, w_cls.subu, w_cls.ori, w_cls.lui:
            w_next = S_EXE;
          w_cls.beq:
            w_next = S_BRANCH;
          w_cls.j, w_cls.jal, w_cls.jr:
            w_next = S_JUMP;
          default:
            w_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: w_next = w_cls.sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
      S_EXE:    w_next = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP:
        w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.memread = 1'b1;
        w_ctrl.alusrcb = SRCB_FOUR;
        w_ctrl.aluop   = ALU_ADD;
        w_ctrl.pcsrc   = PCSRC_ALU;
        // PC and IR only advance once the instruction word is back.
        w_ctrl.irwrite = mem_ready;
        w_ctrl.pcwrite = mem_ready;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        w_ctrl.alusrcb = SRCB_IMMSH;
        w_ctrl.extop   = EXT_SIGN;
        w_ctrl.aluop   = ALU_ADD;
        w_ctrl.illegal = w_cls.illegal;
      end
      S_MEMADR: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_IMM;
        w_ctrl.extop   = EXT_SIGN;
        w_ctrl.aluop   = ALU_ADD;
      end
      S_MEMRD: begin
        w_ctrl.memread = 1'b1;
        w_ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.regdst   = REGDST_RT;
        w_ctrl.memtoreg = MTR_MDR;
        w_ctrl.retire   = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.memwrite = 1'b1;
        w_ctrl.iord     = 1'b1;
        w_ctrl.retire   = mem_ready;
      end
      S_EXE: begin
        w_ctrl.alusrca = 1'b1;
        unique case (1'b1)
          w_cls.subu: begin
            w_ctrl.alusrcb = SRCB_REGB;
            w_ctrl.aluop   = ALU_SUB;
          end
          w_cls.ori: begin
            w_ctrl.alusrcb = SRCB_IMM;
            w_ctrl.extop   = EXT_ZERO;
            w_ctrl.aluop   = ALU_OR;
          end
          w_cls.lui: begin
            // lui = (imm<<16) | $0 on the ALU.
            w_ctrl.alusrcb = SRCB_IMM;
            w_ctrl.extop   = EXT_UPPER;
            w_ctrl.aluop   = ALU_OR;
          end
          default: begin
            w_ctrl.alusrcb = SRCB_REGB;
            w_ctrl.aluop   = ALU_ADD;
          end
        endcase
      end
      S_ALUWB: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memtoreg = MTR_ALUOUT;
        w_ctrl.regdst   = is_imm_alu(w_cls) ? REGDST_RT
                                            : REGDST_RD;
        w_ctrl.retire   = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alusrca     = 1'b1;
        w_ctrl.alusrcb     = SRCB_REGB;
        w_ctrl.aluop       = ALU_SUB;
        w_ctrl.pcwritecond = 1'b1;
        w_ctrl.pcsrc       = PCSRC_ALUOUT;
        w_ctrl.retire      = 1'b1;
      end
      S_JUMP: begin
        w_ctrl.pcwrite = 1'b1;
        w_ctrl.retire  = 1'b1;
        unique case (1'b1)
          w_cls.jr: w_ctrl.pcsrc = PCSRC_REG;
          w_cls.jal: begin
            // PC already holds PC+4 from fetch: that is the link value.
            w_ctrl.pcsrc    = PCSRC_JUMP;
            w_ctrl.regwrite = 1'b1;
            w_ctrl.regdst   = REGDST_RA;
            w_ctrl.memtoreg = MTR_PC;
          end
          default: w_ctrl.pcsrc = PCSRC_JUMP;
        endcase
      end
      default: w_ctrl = '0;
    endcase
  end

  // Reset masks every enable in the same cycle it is asserted.
  assign w_out = reset ? '0 : w_ctrl;

  assign pcwrite     = w_out.pcwrite;
  assign pcwritecond = w_out.pcwritecond;
  assign pcsrc       = w_out.pcsrc;
  assign iord        = w_out.iord;
  assign memread     = w_out.memread;
  assign memwrite    = w_out.memwrite;
  assign irwrite     = w_out.irwrite;
  assign regwrite    = w_out.regwrite;
  assign regdst      = w_out.regdst;
  assign memtoreg    = w_out.memtoreg;
  assign alusrca     = w_out.alusrca;
  assign alusrcb     = w_out.alusrcb;
  assign aluop       = w_out.aluop;
  assign extop       = w_out.extop;
  assign retire      = w_out.retire;
  assign illegal     = w_out.illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm (ILLEGAL_HALT=0 and =1 side by side).
// Stimulus pushes expected output vectors; a negedge monitor compares.
module tb_mc_control_fsm;

  typedef logic [21:0] vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] func = '0;
  logic       mem_ready = 1'b0;

  logic       a_pw, a_pwc, a_iord, a_mr, a_mw, a_irw, a_rw;
  logic       a_asa, a_ret, a_ill;
  logic [1:0] a_pcs, a_rdst, a_mtr, a_asb, a_aop, a_ext;
  logic       b_pw, b_pwc, b_iord, b_mr, b_mw, b_irw, b_rw;
  logic       b_asa, b_ret, b_ill;
  logic [1:0] b_pcs, b_rdst, b_mtr, b_asb, b_aop, b_ext;

  mc_control_fsm #(.ILLEGAL_HALT(1'b0)) u_dut (
    .clk(clk), .reset(reset), .op(op), .func(func),
    .mem_ready(mem_ready),
    .pcwrite(a_pw), .pcwritecond(a_pwc), .pcsrc(a_pcs),
    .iord(a_iord), .memread(a_mr), .memwrite(a_mw),
    .irwrite(a_irw), .regwrite(a_rw), .regdst(a_rdst),
    .memtoreg(a_mtr), .alusrca(a_asa), .alusrcb(a_asb),
    .aluop(a_aop), .extop(a_ext), .retire(a_ret),
    .illegal(a_ill)
  );

  mc_control_fsm #(.ILLEGAL_HALT(1'b1)) u_halt (
    .clk(clk), .reset(reset), .op(op), .func(func),
    .mem_ready(mem_ready),
    .pcwrite(b_pw), .pcwritecond(b_pwc), .pcsrc(b_pcs),
    .iord(b_iord), .memread(b_mr), .memwrite(b_mw),
    .irwrite(b_irw), .regwrite(b_rw), .regdst(b_rdst),
    .memtoreg(b_mtr), .alusrca(b_asa), .alusrcb(b_asb),
    .aluop(b_aop), .extop(b_ext), .retire(b_ret),
    .illegal(b_ill)
  );

  always #5 clk = ~clk;

  vec_t out_a, out_b;
  assign out_a = {a_pw, a_pwc, a_pcs, a_iord, a_mr, a_mw, a_irw,
                  a_rw, a_rdst, a_mtr, a_asa, a_asb, a_aop, a_ext,
                  a_ret, a_ill};
  assign out_b = {b_pw, b_pwc, b_pcs, b_iord, b_mr, b_mw, b_irw,
                  b_rw, b_rdst, b_mtr, b_asa, b_asb, b_aop, b_ext,
                  b_ret, b_ill};

  function automatic vec_t mk(
    input logic pw, input logic pwc, input logic [1:0] pcs,
    input logic iord, input logic mr, input logic mw,
    input logic irw, input logic rw, input logic [1:0] rdst,
    input logic [1:0] mtr, input logic asa, input logic [1:0] asb,
    input logic [1:0] aop, input logic [1:0] ext,
    input logic ret, input logic ill);
    return {pw, pwc, pcs, iord, mr, mw, irw, rw, rdst, mtr,
            asa, asb, aop, ext, ret, ill};
  endfunction

  int checks = 0;
  int errors = 0;

  logic [43:0] exp_q[$];
  string       name_q[$];

  logic [43:0] e_cur;
  string       n_cur;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e_cur = exp_q.pop_front();
      n_cur = name_q.pop_front();
      checks++;
      if (out_a !== e_cur[43:22]) begin
        errors++;
        $display("FAIL %s dut0: got %h expected %h",
                 n_cur, out_a, e_cur[43:22]);
      end
      checks++;
      if (out_b !== e_cur[21:0]) begin
        errors++;
        $display("FAIL %s dut_halt: got %h expected %h",
                 n_cur, out_b, e_cur[21:0]);
      end
    end
  end

  task automatic step(input logic rst, input logic rdy,
                      input logic [31:0] ins, input vec_t e0,
                      input vec_t e1, input string nm);
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = rdy;
    op        = ins[31:26];
    func      = ins[5:0];
    exp_q.push_back({e0, e1});
    name_q.push_back(nm);
  endtask

  task automatic step2(input logic rst, input logic rdy,
                       input logic [31:0] ins, input vec_t e,
                       input string nm);
    step(rst, rdy, ins, e, e, nm);
  endtask

  localparam logic [31:0] I_ADDU  = 32'h00221821;
  localparam logic [31:0] I_SUBU  = 32'h00221823;
  localparam logic [31:0] I_LW    = 32'h8C220004;
  localparam logic [31:0] I_SW    = 32'hAC220004;
  localparam logic [31:0] I_ORI   = 32'h342200FF;
  localparam logic [31:0] I_LUI   = 32'h3C021234;
  localparam logic [31:0] I_BEQ   = 32'h10220003;
  localparam logic [31:0] I_J     = 32'h08000010;
  localparam logic [31:0] I_JAL   = 32'h0C000010;
  localparam logic [31:0] I_JR    = 32'h03E00008;
  localparam logic [31:0] I_BADOP = 32'hFC000000;
  localparam logic [31:0] I_BADFN = 32'h0000003F;

  vec_t Z, FW, FR, DE, DI, MA, MRD, MWB, MWW, MWR;
  vec_t EXA, EXS, EXO, EXL, WBR, WBI, BR, JJ, JAL, JR;

  initial begin
    //      pw pwc pcs   io mr mw ir rw rdst  mtr   asa asb   aop   ext   rt il
    Z   = '0;
    FW  = mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    FR  = mk(1, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    DE  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b01, 0, 0);
    DI  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b01, 0, 1);
    MA  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b00, 2'b01, 0, 0);
    MRD = mk(0, 0, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    MWB = mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    MWW = mk(0, 0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    MWR = mk(0, 0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    EXA = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0);
    EXS = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 2'b00, 0, 0);
    EXO = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b10, 2'b00, 0, 0);
    EXL = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b10, 2'b10, 0, 0);
    WBR = mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    WBI = mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    BR  = mk(0, 1, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 2'b00, 1, 0);
    JJ  = mk(1, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    JAL = mk(1, 0, 2'b10, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    JR  = mk(1, 0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0);

    step2(1, 1, I_ADDU, Z, "reset0");
    step2(1, 1, I_ADDU, Z, "reset1");

    step2(0, 1, I_ADDU, FR,  "addu_fetch");
    step2(0, 1, I_ADDU, DE,  "addu_dec");
    step2(0, 1, I_ADDU, EXA, "addu_exe");
    step2(0, 1, I_ADDU, WBR, "addu_wb");

    step2(0, 0, I_SUBU, FW,  "stall_fetch0");
    step2(0, 0, I_SUBU, FW,  "stall_fetch1");
    step2(0, 1, I_SUBU, FR,  "stall_fetch_rdy");
    step2(0, 1, I_SUBU, DE,  "subu_dec");
    step2(0, 1, I_SUBU, EXS, "subu_exe");
    step2(0, 1, I_SUBU, WBR, "subu_wb");

    step2(0, 1, I_LW, FR,  "lw_fetch");
    step2(0, 1, I_LW, DE,  "lw_dec");
    step2(0, 0, I_LW, MA,  "lw_memadr");
    step2(0, 0, I_LW, MRD, "lw_rd_wait0");
    step2(0, 0, I_LW, MRD, "lw_rd_wait1");
    step2(0, 0, I_LW, MRD, "lw_rd_wait2");
    step2(0, 1, I_LW, MRD, "lw_rd_rdy");
    step2(0, 1, I_LW, MWB, "lw_wb");

    step2(0, 1, I_SW, FR,  "sw_fetch");
    step2(0, 1, I_SW, DE,  "sw_dec");
    step2(0, 0, I_SW, MA,  "sw_memadr");
    step2(0, 0, I_SW, MWW, "sw_wr_wait");
    step2(0, 1, I_SW, MWR, "sw_wr_rdy");

    step2(0, 1, I_ORI, FR,  "ori_fetch");
    step2(0, 1, I_ORI, DE,  "ori_dec");
    step2(0, 1, I_ORI, EXO, "ori_exe");
    step2(0, 1, I_ORI, WBI, "ori_wb");
    step2(0, 1, I_LUI, FR,  "lui_fetch");
    step2(0, 1, I_LUI, DE,  "lui_dec");
    step2(0, 1, I_LUI, EXL, "lui_exe");
    step2(0, 1, I_LUI, WBI, "lui_wb");

    step2(0, 1, I_BEQ, FR,  "beq_fetch");
    step2(0, 1, I_BEQ, DE,  "beq_dec");
    step2(0, 1, I_BEQ, BR,  "beq_branch");
    step2(0, 1, I_J,   FR,  "j_fetch");
    step2(0, 1, I_J,   DE,  "j_dec");
    step2(0, 1, I_J,   JJ,  "j_jump");
    step2(0, 1, I_JAL, FR,  "jal_fetch");
    step2(0, 1, I_JAL, DE,  "jal_dec");
    step2(0, 1, I_JAL, JAL, "jal_jump");
    step2(0, 1, I_JR,  FR,  "jr_fetch");
    step2(0, 1, I_JR,  DE,  "jr_dec");
    step2(0, 1, I_JR,  JR,  "jr_jump");

    step2(0, 1, I_LW, FR,  "rlw_fetch");
    step2(0, 1, I_LW, DE,  "rlw_dec");
    step2(0, 0, I_LW, MA,  "rlw_memadr");
    step2(0, 0, I_LW, MRD, "rlw_rd_wait");
    step2(1, 0, I_LW, Z,   "rlw_reset");
    step2(0, 0, I_LW, FW,  "rlw_refetch");

    step2(0, 1, I_BADOP, FR, "badop_fetch");
    step2(0, 1, I_BADOP, DI, "badop_dec");
    step (0, 0, I_BADOP, FW, Z, "badop_after0");
    step (0, 1, I_BADOP, FR, Z, "badop_after1");
    step2(1, 0, I_BADOP, Z,  "badop_reset");

    step2(0, 1, I_BADFN, FR, "badfn_fetch");
    step2(0, 1, I_BADFN, DI, "badfn_dec");
    step (0, 0, I_BADFN, FW, Z, "badfn_after");
    step2(1, 0, I_BADFN, Z,  "badfn_reset");
    step2(0, 0, I_ADDU,  FW, "final_fetch");

    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
